// File: rtl/rv_pkg.sv
// Shared integer-pipeline types: register width, register address width and
// the write-back entry carried from long-latency units to the register file.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering long-latency write-back results. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    wb_entry_t   mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + PTR_ONE;
            if (pop && !empty)
                rptr <= rptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port controller: merges ALU and buffered long-latency
// results into one registered write per cycle and tracks pending destinations.
module reg_wb_ctrl
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_wr,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              iss_long,
    input  logic [REG_AW-1:0] iss_rd,
    output logic              iss_ready,
    input  logic              lng_valid,
    output logic              lng_ready,
    input  logic [REG_AW-1:0] lng_rd,
    input  logic [XLEN-1:0]   lng_data,
    input  logic [REG_AW-1:0] raddrA,
    input  logic [REG_AW-1:0] raddrB,
    output logic              busyA,
    output logic              busyB,
    output logic              wr,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              waw_err
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    wb_entry_t        fifo_din;
    wb_entry_t        fifo_head;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_from_fifo;

    assign lng_ready = !fifo_full;
    assign fifo_push = lng_valid && lng_ready;
    assign fifo_pop  = !alu_wr && !fifo_empty;
    assign fifo_din  = '{rd: lng_rd, data: lng_data};

    assign iss_ready = !busy[iss_rd] || (iss_rd == '0);
    assign busyA     = busy[raddrA] && (raddrA != '0);
    assign busyB     = busy[raddrB] && (raddrB != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Clear lands on the edge the register file captures the buffered result.
    // NOTE: busy_nxt is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_nxt = busy;
        if (wr && wr_from_fifo && (waddr != '0))
            busy_nxt[waddr] = 1'b0;
        if (iss_long && iss_ready && (iss_rd != '0))
            busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= '0;
            wr           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            wr_from_fifo <= 1'b0;
            waw_err      <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (alu_wr && (alu_rd != '0) && busy[alu_rd])
                waw_err <= 1'b1;
            if (alu_wr) begin
                wr           <= (alu_rd != '0);
                waddr        <= alu_rd;
                wdata        <= alu_data;
                wr_from_fifo <= 1'b0;
            end else if (!fifo_empty) begin
                wr           <= (fifo_head.rd != '0);
                waddr        <= fifo_head.rd;
                wdata        <= fifo_head.data;
                wr_from_fifo <= 1'b1;
            end else begin
                wr           <= 1'b0;
                wr_from_fifo <= 1'b0;
            end
        end
    end

endmodule
